// File: rtl/afu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : afu_pkg
//  Description : Shared types and constants for the AFU streaming controller.
//                Holds the 512-bit cache-line type, the 32-bit job counter
//                type and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package afu_pkg;

    localparam int unsigned C_LINE_W = 512;
    localparam int unsigned C_CNT_W  = 32;

    // One host cache line as moved through the read, compute and write paths.
    typedef logic [C_LINE_W-1:0] afu_line_t;

    // Line counters and line indices within a job.
    typedef logic [C_CNT_W-1:0] afu_cnt_t;

    // Controller state encoding. The fixed-width constants keep the encoding
    // stable for anything that decodes the raw state bits.
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_RUN  = C_ST_RUN,
        ST_DONE = C_ST_DONE
    } afu_state_e;

endpackage : afu_pkg
`default_nettype wire

// File: rtl/afu_skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module      : afu_skid_buf2
//  Description : Two-entry in-order line buffer between the compute output
//                FIFO and the host write channel. The head entry is presented
//                on data/valid and stays stable until popped with ready.
//  Ports       : clk, reset      - clock, asynchronous active-high reset
//                flush           - synchronous clear of all entries
//                push, push_data - write one line into the tail
//                valid, data     - head entry
//                ready           - consumer accepts the head entry
//                count           - current occupancy (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module afu_skid_buf2
    import afu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  afu_line_t  push_data,
    output logic       valid,
    output afu_line_t  data,
    input  logic       ready,
    output logic [1:0] count
);

    afu_line_t  r_head;
    afu_line_t  r_tail;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop = (r_count != 2'd0) && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (push) begin
                        r_head  <= push_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, w_pop})
                        2'b10: begin
                            r_tail  <= push_data;
                            r_count <= 2'd2;
                        end
                        // Head leaves while the new line arrives: the new
                        // line becomes the head directly.
                        2'b11: r_head  <= push_data;
                        2'b01: r_count <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // A push while full without a pop cannot occur: the read
                    // enable throttle upstream accounts for in-flight lines.
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (push) begin
                            r_tail <= push_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    assign valid = (r_count != 2'd0);
    assign data  = r_head;
    assign count = r_count;

endmodule : afu_skid_buf2
`default_nettype wire

// File: rtl/afu_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : afu_stream_ctrl
//  Description : Job controller for a streaming accelerator. Reads ctx_length
//                lines from host memory (bounded outstanding requests),
//                feeds the responses into the compute input FIFO, drains the
//                compute output FIFO through a 2-entry buffer and writes the
//                results back to host line indices 0..ctx_length-1.
//  Ports       : clk, reset               - clock, async active-high reset
//                start, ctx_length        - job launch and length in lines
//                busy, done               - job status, done is a 1-cycle pulse
//                rd_req_*                 - host read request channel
//                rd_rsp_*                 - in-order host read responses
//                input_fifo_*             - compute FIFO feed side
//                output_fifo_*            - compute FIFO drain side
//                wr_req_*                 - host write channel
//  Revision    : 1.0 - initial release
// ============================================================================
module afu_stream_ctrl
    import afu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        start,
    input  logic [31:0] ctx_length,
    output logic        busy,
    output logic        done,

    output logic        rd_req_valid,
    output logic [31:0] rd_req_idx,
    input  logic        rd_req_ready,

    input  logic        rd_rsp_valid,
    input  afu_line_t   rd_rsp_data,

    output afu_line_t   input_fifo_din,
    output logic        input_fifo_we,
    input  logic        input_fifo_almost_full,

    input  afu_line_t   output_fifo_dout,
    output logic        output_fifo_re,
    input  logic        output_fifo_empty,

    output logic        wr_req_valid,
    output logic [31:0] wr_req_idx,
    output afu_line_t   wr_req_data,
    input  logic        wr_req_ready
);

    localparam int              C_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [C_OUT_W-1:0] C_MAX_OUT = C_OUT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    afu_state_e         r_state;
    afu_cnt_t           r_len;
    afu_cnt_t           r_rd_cnt;
    afu_cnt_t           r_wr_cnt;
    logic [C_OUT_W-1:0] r_outstanding;
    logic               r_re_q;         // output FIFO read issued last cycle

    logic               w_run;
    logic               w_start_job;
    logic               w_rd_fire;
    logic               w_wr_fire;
    logic               w_re;
    logic [2:0]         w_proj_occ;

    logic               w_buf_valid;
    afu_line_t          w_buf_data;
    logic [1:0]         w_buf_count;

    assign w_run       = (r_state == ST_RUN);
    assign w_start_job = (r_state == ST_IDLE) && start;
    assign w_rd_fire   = rd_req_valid && rd_req_ready;
    assign w_wr_fire   = wr_req_valid && wr_req_ready;

    // ------------------------------------------------------------------
    // Job state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_len   <= ctx_length;
                    end
                end
                // Completion is decided on the registered write count, so a
                // zero-length job still spends one cycle in RUN.
                ST_RUN: begin
                    if (r_wr_cnt == r_len) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read / write / outstanding counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_outstanding <= '0;
        end else if (w_start_job) begin
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            // Issue and response in the same cycle cancel out. The zero guard
            // keeps stray responses from a job aborted by reset from
            // wrapping the count.
            case ({w_rd_fire, rd_rsp_valid})
                2'b10: r_outstanding <= r_outstanding + 1'b1;
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Host read request channel
    // ------------------------------------------------------------------
    assign rd_req_valid = w_run
                       && (r_rd_cnt < r_len)
                       && (r_outstanding < C_MAX_OUT)
                       && !input_fifo_almost_full;
    assign rd_req_idx   = r_rd_cnt;

    // Responses go straight into the compute FIFO; masked while reset is
    // asserted so the feed side is quiet during an abort.
    assign input_fifo_we  = rd_rsp_valid && !reset;
    assign input_fifo_din = reset ? '0 : rd_rsp_data;

    // ------------------------------------------------------------------
    // Output FIFO drain
    // ------------------------------------------------------------------
    // Projected occupancy one cycle ahead: current entries, minus the one
    // leaving on the write channel now, plus the line already requested last
    // cycle that lands next cycle. Reading only when that is below 2 means
    // the line requested now always has a free slot when it arrives.
    assign w_proj_occ = {1'b0, w_buf_count} + {2'b00, r_re_q} - {2'b00, w_wr_fire};
    assign w_re       = w_run && !output_fifo_empty && (w_proj_occ < 3'd2);
    assign output_fifo_re = w_re;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_re_q <= 1'b0;
        end else begin
            r_re_q <= w_re;
        end
    end

    // dout is valid the cycle after re, so the delayed re is the push strobe.
    afu_skid_buf2 u_drain_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_start_job),
        .push      (r_re_q),
        .push_data (output_fifo_dout),
        .valid     (w_buf_valid),
        .data      (w_buf_data),
        .ready     (wr_req_ready),
        .count     (w_buf_count)
    );

    // ------------------------------------------------------------------
    // Host write channel and status
    // ------------------------------------------------------------------
    assign wr_req_valid = w_run && w_buf_valid;
    assign wr_req_idx   = r_wr_cnt;
    assign wr_req_data  = w_buf_data;

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule : afu_stream_ctrl
`default_nettype wire

// File: tb/tb_afu_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_afu_stream_ctrl
//  Description : Self-checking bench for afu_stream_ctrl. Models the host
//                read responder (in-order, 1-cycle latency, optional hold),
//                a loopback compute FIFO and the host write sink; job
//                configurations come from a vector table, with hand-written
//                sequences for response throttling and mid-job reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_afu_stream_ctrl;

    localparam int MAX_OUT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  ctx_length;
    logic         busy;
    logic         done;
    logic         rd_req_valid;
    logic [31:0]  rd_req_idx;
    logic         rd_req_ready;
    logic         rd_rsp_valid;
    logic [511:0] rd_rsp_data;
    logic [511:0] input_fifo_din;
    logic         input_fifo_we;
    logic         input_fifo_almost_full;
    logic [511:0] output_fifo_dout;
    logic         output_fifo_re;
    logic         output_fifo_empty;
    logic         wr_req_valid;
    logic [31:0]  wr_req_idx;
    logic [511:0] wr_req_data;
    logic         wr_req_ready;

    always #5 clk = ~clk;

    afu_stream_ctrl #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .ctx_length             (ctx_length),
        .busy                   (busy),
        .done                   (done),
        .rd_req_valid           (rd_req_valid),
        .rd_req_idx             (rd_req_idx),
        .rd_req_ready           (rd_req_ready),
        .rd_rsp_valid           (rd_rsp_valid),
        .rd_rsp_data            (rd_rsp_data),
        .input_fifo_din         (input_fifo_din),
        .input_fifo_we          (input_fifo_we),
        .input_fifo_almost_full (input_fifo_almost_full),
        .output_fifo_dout       (output_fifo_dout),
        .output_fifo_re         (output_fifo_re),
        .output_fifo_empty      (output_fifo_empty),
        .wr_req_valid           (wr_req_valid),
        .wr_req_idx             (wr_req_idx),
        .wr_req_data            (wr_req_data),
        .wr_req_ready           (wr_req_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Job-level model state
    int           tag, s, done_at, done_count;
    int           rd_fires, wr_fires, rd_valid_cycles, wr_valid_cycles;
    int           max_occ, occ_viol, af_viol, re_cnt;
    bit           re_last;
    logic [31:0]  exp_rd_idx, exp_wr_idx;
    bit           wr_toggle;
    int           af_start, restart_at;
    bit           hold_rsp;
    int           release_cnt;
    bit           prev_stall;
    logic [31:0]  prev_idx;
    logic [511:0] prev_data;
    logic [31:0]  pend[$];
    logic [511:0] ofifo[$];

    typedef struct {
        int len;
        bit wtog;
        int af_start;
        int restart_at;
        int exp_xfers;
        int exp_done_at;   // -1: not checked
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] line_of(input int t, input logic [31:0] idx);
        logic [31:0] w;
        w = (32'(t) << 24) ^ 32'h005A_0000 ^ idx;
        return {16{w}};
    endfunction

    task automatic step_cycle();
        bit           rdf, wrf, re_s, we_s;
        logic [31:0]  ridx, idx;
        logic [511:0] din_s;
        int           occ;
        @(negedge clk);
        rdf   = rd_req_valid && rd_req_ready;
        wrf   = wr_req_valid && wr_req_ready;
        re_s  = output_fifo_re;
        we_s  = input_fifo_we;
        din_s = input_fifo_din;
        ridx  = rd_req_idx;
        if (done) begin
            done_count++;
            if (done_at < 0) done_at = s;
        end
        if (rd_req_valid) rd_valid_cycles++;
        if (wr_req_valid) wr_valid_cycles++;
        if (rd_req_valid && input_fifo_almost_full) af_viol++;
        if (rdf) begin
            chk("rd_idx", 512'(rd_req_idx), 512'(exp_rd_idx));
            exp_rd_idx++;
            rd_fires++;
        end
        if (prev_stall) begin
            chk("wr_hold_valid", 512'(wr_req_valid), 512'(1'b1));
            chk("wr_hold_idx", 512'(wr_req_idx), 512'(prev_idx));
            chk("wr_hold_data", wr_req_data, prev_data);
        end
        prev_stall = wr_req_valid && !wr_req_ready;
        prev_idx   = wr_req_idx;
        prev_data  = wr_req_data;
        if (wrf) begin
            chk("wr_idx", 512'(wr_req_idx), 512'(exp_wr_idx));
            chk("wr_data", wr_req_data, line_of(tag, exp_wr_idx));
            exp_wr_idx++;
        end
        // Buffer occupancy: lines read from the output FIFO two or more
        // cycles ago have landed; subtract lines already written.
        occ = (re_cnt - int'(re_last)) - wr_fires;
        if (occ > max_occ) max_occ = occ;
        if (wr_req_valid != (occ > 0)) occ_viol++;
        re_cnt += int'(re_s);
        re_last = re_s;
        if (wrf) wr_fires++;

        @(posedge clk);
        #1;
        if (re_s && ofifo.size() > 0) output_fifo_dout = ofifo.pop_front();
        if (we_s) ofifo.push_back(din_s);
        if (rdf) pend.push_back(ridx);
        rd_rsp_valid = 1'b0;
        if (pend.size() > 0 && (!hold_rsp || release_cnt > 0)) begin
            idx          = pend.pop_front();
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = line_of(tag, idx);
            if (hold_rsp) release_cnt--;
        end
        output_fifo_empty = (ofifo.size() == 0);
        s++;
        wr_req_ready = wr_toggle ? ~wr_req_ready : 1'b1;
        input_fifo_almost_full = (af_start >= 0) && (s >= af_start) && (s < af_start + 10);
        start = (s == restart_at);
        if (start) ctx_length = 32'd99;
    endtask

    task automatic begin_job(input int len, input int t, input bit wtog,
                             input int afs, input int rs_at);
        tag = t; s = 0; done_at = -1; done_count = 0;
        rd_fires = 0; wr_fires = 0; rd_valid_cycles = 0; wr_valid_cycles = 0;
        max_occ = 0; occ_viol = 0; af_viol = 0; re_cnt = 0; re_last = 1'b0;
        exp_rd_idx = '0; exp_wr_idx = '0; prev_stall = 1'b0;
        wr_toggle = wtog; af_start = afs; restart_at = rs_at;
        hold_rsp = 1'b0; release_cnt = 0;
        wr_req_ready = 1'b1;
        input_fifo_almost_full = (afs == 0);
        ctx_length = 32'(len);
        start = 1'b1;
    endtask

    task automatic finish_job(input int exp_xfers, input int exp_done_at, input int budget);
        int n = 0;
        while (done_at < 0 && n < budget) begin
            step_cycle();
            n++;
        end
        chk("job_done_seen", 512'(done_at >= 0), 512'(1'b1));
        step_cycle();
        chk("done_pulse_count", 512'(done_count), 512'(1));
        chk("busy_after_done", 512'(busy), 512'(1'b0));
        chk("read_count", 512'(rd_fires), 512'(exp_xfers));
        chk("write_count", 512'(wr_fires), 512'(exp_xfers));
        chk("max_occupancy_le_2", 512'(max_occ <= 2), 512'(1'b1));
        chk("wr_valid_vs_occupancy", 512'(occ_viol), 512'(0));
        chk("read_while_almost_full", 512'(af_viol), 512'(0));
        chk("responses_drained", 512'(pend.size()), 512'(0));
        chk("fifo_drained", 512'(ofifo.size()), 512'(0));
        if (exp_xfers == 0) begin
            chk("no_rd_valid", 512'(rd_valid_cycles), 512'(0));
            chk("no_wr_valid", 512'(wr_valid_cycles), 512'(0));
        end
        if (exp_done_at >= 0) chk("done_latency", 512'(done_at), 512'(exp_done_at));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //          len wtog afs restart xfers done_at
        vecs[0] = '{0,  1'b0, -1, -1,  0,  2};
        vecs[1] = '{8,  1'b0, -1,  3,  8, -1};
        vecs[2] = '{6,  1'b1, -1, -1,  6, -1};
        vecs[3] = '{12, 1'b0,  4, -1, 12, -1};
        vecs[4] = '{1,  1'b0, -1, -1,  1,  7};

        reset = 1'b1; start = 1'b0; ctx_length = '0;
        rd_req_ready = 1'b1; rd_rsp_valid = 1'b1; rd_rsp_data = {16{32'hDEAD_BEEF}};
        input_fifo_almost_full = 1'b0; output_fifo_dout = '0; output_fifo_empty = 1'b0;
        wr_req_ready = 1'b1; hold_rsp = 1'b0; release_cnt = 0;
        wr_toggle = 1'b0; af_start = -1; restart_at = -1; tag = 0; s = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 512'(busy), 512'(1'b0));
        chk("reset_done", 512'(done), 512'(1'b0));
        chk("reset_rd_valid", 512'(rd_req_valid), 512'(1'b0));
        chk("reset_wr_valid", 512'(wr_req_valid), 512'(1'b0));
        chk("reset_fifo_re", 512'(output_fifo_re), 512'(1'b0));
        chk("reset_fifo_we", 512'(input_fifo_we), 512'(1'b0));
        chk("reset_fifo_din", input_fifo_din, 512'(0));
        chk("reset_rd_idx", 512'(rd_req_idx), 512'(0));
        chk("reset_wr_idx", 512'(wr_req_idx), 512'(0));
        chk("reset_wr_data", wr_req_data, 512'(0));
        rd_rsp_valid = 1'b0; output_fifo_empty = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            begin_job(vecs[i].len, i + 1, vecs[i].wtog, vecs[i].af_start, vecs[i].restart_at);
            finish_job(vecs[i].exp_xfers, vecs[i].exp_done_at, 300);
        end

        // Responses withheld: issue stops at the outstanding limit and one
        // response lets exactly one more request through.
        begin_job(16, 10, 1'b0, -1, -1);
        hold_rsp = 1'b1;
        repeat (8) step_cycle();
        chk("hold_rd_fires", 512'(rd_fires), 512'(MAX_OUT));
        chk("hold_rd_valid_low", 512'(rd_req_valid), 512'(1'b0));
        release_cnt = 1;
        repeat (3) step_cycle();
        chk("release_rd_fires", 512'(rd_fires), 512'(MAX_OUT + 1));
        chk("release_rd_valid_cycles", 512'(rd_valid_cycles), 512'(MAX_OUT + 1));
        chk("release_rd_valid_low", 512'(rd_req_valid), 512'(1'b0));
        hold_rsp = 1'b0;
        finish_job(16, -1, 400);

        // Reset mid-job after three writes, then a clean short job.
        begin_job(8, 20, 1'b0, -1, -1);
        n = 0;
        while (wr_fires < 3 && n < 100) begin
            step_cycle();
            n++;
        end
        chk("pre_reset_writes", 512'(wr_fires), 512'(3));
        reset = 1'b1;
        #1;
        chk("abort_busy", 512'(busy), 512'(1'b0));
        chk("abort_done", 512'(done), 512'(1'b0));
        chk("abort_rd_valid", 512'(rd_req_valid), 512'(1'b0));
        chk("abort_wr_valid", 512'(wr_req_valid), 512'(1'b0));
        chk("abort_fifo_we", 512'(input_fifo_we), 512'(1'b0));
        chk("abort_fifo_re", 512'(output_fifo_re), 512'(1'b0));
        chk("abort_rd_idx", 512'(rd_req_idx), 512'(0));
        chk("abort_wr_idx", 512'(wr_req_idx), 512'(0));
        chk("abort_wr_data", wr_req_data, 512'(0));
        chk("abort_fifo_din", input_fifo_din, 512'(0));
        chk("abort_no_done_pulse", 512'(done_count), 512'(0));
        pend.delete();
        ofifo.delete();
        rd_rsp_valid = 1'b0;
        output_fifo_empty = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_idle", 512'(busy), 512'(1'b0));
        begin_job(2, 21, 1'b0, -1, -1);
        finish_job(2, -1, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_afu_stream_ctrl
`default_nettype wire

// File: doc/afu_stream_ctrl.md
AFU_STREAM_CTRL -- requirements
Module: afu_stream_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of host read requests issued but not yet answered.
REQ-002 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-003 SHALL have ports start (in, 1, begin job) and ctx_length (in, 32, job length in 512-bit lines).
REQ-004 SHALL have ports busy (out, 1, job active) and done (out, 1, one-cycle completion pulse).
REQ-005 SHALL have ports rd_req_valid (out, 1), rd_req_idx (out, 32, line index) and rd_req_ready (in, 1): host read request channel.
REQ-006 SHALL have ports rd_rsp_valid (in, 1) and rd_rsp_data (in, 512): in-order host read responses, no backpressure.
REQ-007 SHALL have ports input_fifo_din (out, 512), input_fifo_we (out, 1) and input_fifo_almost_full (in, 1): feed side of the compute FIFO.
REQ-008 SHALL have ports output_fifo_dout (in, 512), output_fifo_re (out, 1) and output_fifo_empty (in, 1): drain side of the compute FIFO; dout is valid the cycle after re.
REQ-009 SHALL have ports wr_req_valid (out, 1), wr_req_idx (out, 32), wr_req_data (out, 512) and wr_req_ready (in, 1): host write channel.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, latching ctx_length into len_q and clearing all counters.
REQ-011 SHALL ignore start outside IDLE.
REQ-012 SHALL go RUN->DONE in the cycle after wr_cnt reaches len_q, and DONE->IDLE after exactly one cycle; done=1 only in DONE.
REQ-013 SHALL go IDLE->RUN->DONE with no host traffic when ctx_length=0.
REQ-014 SHALL hold busy=1 in RUN and DONE and busy=0 in IDLE.
REQ-015 SHALL assert rd_req_valid in RUN iff rd_cnt<len_q, outstanding<MAX_OUTSTANDING and input_fifo_almost_full=0; rd_req_idx=rd_cnt.
REQ-016 SHALL count a read as issued (rd_cnt+1, outstanding+1) only on rd_req_valid and rd_req_ready both high.
REQ-017 SHALL drive input_fifo_we=rd_rsp_valid and input_fifo_din=rd_rsp_data combinationally, and decrement outstanding on each response.
REQ-018 SHALL leave outstanding unchanged when an issue and a response occur in the same cycle.
REQ-019 SHALL drain the output FIFO through a 2-entry in-order buffer with output_fifo_re=!output_fifo_empty and (occupancy - consume_this_cycle + inflight_re)<2, where inflight_re is the previous cycle's re.
REQ-020 SHALL capture output_fifo_dout into the buffer in the cycle after re; never overflow; sustain 1 line/cycle while wr_req_ready=1.
REQ-021 SHALL present the buffer head on wr_req_data with wr_req_valid = buffer non-empty; wr_req_idx=wr_cnt; wr_cnt+1 on valid and ready.
REQ-022 SHALL hold wr_req_data and wr_req_idx stable while wr_req_valid=1 and wr_req_ready=0.
REQ-023 SHALL keep all counters 32-bit unsigned with no wrap within a job; outstanding is clog2(MAX_OUTSTANDING+1) bits.

Reset
REQ-024 SHALL on reset asynchronously force IDLE, clear all counters and the buffer, and drive busy, done, rd_req_valid, input_fifo_we, output_fifo_re and wr_req_valid to 0 and all idx/data outputs to 0.
REQ-025 SHALL abort the job on reset mid-RUN without a done pulse; responses to reads issued before reset are dropped by the surrounding system.

Structure
REQ-026 SHALL place the state enum and the 512-bit line typedef in shared package afu_pkg.
REQ-027 SHALL implement the 2-entry drain buffer as sub-module afu_skid_buf2 (512-bit, valid/ready out, push in).

Verification
REQ-028 SHALL verify ctx_length=0, start: done pulses exactly 2 cycles after start; no rd_req_valid or wr_req_valid.
REQ-029 SHALL verify ctx_length=8, all readies 1, 1-cycle response latency, loopback FIFO: 8 reads with idx 0..7, 8 writes with idx 0..7 in order, data matches.
REQ-030 SHALL verify rd_rsp withheld with ctx_length=16: rd_req_valid drops after exactly 4 accepted requests and resumes after one response.
REQ-031 SHALL verify input_fifo_almost_full held 1 for 10 cycles mid-job: no read issued during those cycles; job completes with correct count.
REQ-032 SHALL verify wr_req_ready toggled 1/0 each cycle with ctx_length=6: no line lost or duplicated; output_fifo_re never makes the buffer exceed 2 entries.
REQ-033 SHALL verify reset asserted in RUN after 3 writes: all outputs 0 same cycle; a new start with ctx_length=2 runs cleanly from idx 0.
